// File: rtl/cl_axis_test_slave_pkg.sv
// cl_axis_test_slave_pkg
//   Shared definitions for the AXI-stream test slave:
//   - FSM state encoding (IDLE, RECV, DONE)
//   - backpressure LFSR width, seed and tap mask
//   - status counter widths
//   - axis_bus_width(): packed width of the stream bus, laid out
//     MSB..LSB as {tdata, tlast, tvalid, tkeep}
package cl_axis_test_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Fibonacci LFSR with taps 8,6,5,4 (bit positions 7,5,4,3)
  localparam int         lfsr_width_c = 8;
  localparam logic [7:0] lfsr_seed_c  = 8'hA5;
  localparam logic [7:0] lfsr_taps_c  = 8'hB8;

  localparam int pos_cnt_width_c  = 16;
  localparam int err_cnt_width_c  = 16;
  localparam int beat_cnt_width_c = 32;

  // tdata + one tkeep bit per byte + tlast + tvalid
  function automatic int axis_bus_width(input int data_width);
    return data_width + data_width / 8 + 2;
  endfunction

endpackage

// File: rtl/cl_axis_lfsr.sv
// cl_axis_lfsr
//   Free-running Fibonacci LFSR used to generate pseudo-random
//   backpressure. Shifts left every cycle; the XOR of the tapped bits
//   enters at bit 0.
//   Ports:
//     clk_i      clock
//     reset_n_i  asynchronous active-low reset, loads seed_p
//     out_o      current LSB of the register
module cl_axis_lfsr
  import cl_axis_test_slave_pkg::*;
#(
  parameter int                 width_p = lfsr_width_c,
  parameter logic [width_p-1:0] seed_p  = lfsr_seed_c,
  parameter logic [width_p-1:0] taps_p  = lfsr_taps_c
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic out_o
);

  logic [width_p-1:0] lfsr_reg;
  logic               feedback;

  assign feedback = ^(lfsr_reg & taps_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_reg <= seed_p;
    end else begin
      lfsr_reg <= {lfsr_reg[width_p-2:0], feedback};
    end
  end

  assign out_o = lfsr_reg[0];

endmodule

// File: rtl/cl_axis_test_slave.sv
// cl_axis_test_slave
//   AXI-stream checker at the far end of the incrementing-pattern test
//   master. Every accepted beat is checked for the expected byte pattern
//   (all lanes equal, +1 per beat starting at 8'h00), for tlast on the
//   last beat of each packet and for a full tkeep. Beats, packets and
//   failed beats are counted; done_o rises after pkts_num_p packets.
//
//   Optional build macro: CL_AXIS_TEST_SLAVE_BACKPRESSURE_EN
//     When defined, tready is additionally gated by an 8-bit LFSR.
//
//   Ports:
//     clk_i         clock
//     reset_n_i     asynchronous active-low reset
//     en_i          enable; low pauses reception
//     s_axis_bus_i  packed {tdata, tlast, tvalid, tkeep}
//     s_axis_bus_o  packed miso; tready in bit 0, other bits zero
//     done_o        sticky, all packets received
//     err_o         sticky, any beat failed a check
//     err_cnt_o     failed beats, saturating
//     beat_cnt_o    accepted beats, wrapping
module cl_axis_test_slave
  import cl_axis_test_slave_pkg::*;
#(
  parameter  int data_width_p      = 512,
  parameter  int packet_size_p     = 16,
  parameter  int pkts_num_p        = 240,
  localparam int axis_bus_width_lp = axis_bus_width(data_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        en_i,
  input  logic [axis_bus_width_lp-1:0] s_axis_bus_i,
  output logic [axis_bus_width_lp-1:0] s_axis_bus_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [err_cnt_width_c-1:0]  err_cnt_o,
  output logic [beat_cnt_width_c-1:0] beat_cnt_o
);

  localparam int keep_width_lp = data_width_p / 8;
  localparam logic [pos_cnt_width_c-1:0] last_t_lp = pos_cnt_width_c'(packet_size_p - 1);
  localparam logic [pos_cnt_width_c-1:0] last_p_lp = pos_cnt_width_c'(pkts_num_p - 1);

  logic [data_width_p-1:0]  tdata;
  logic [keep_width_lp-1:0] tkeep;
  logic                     tlast;
  logic                     tvalid;

  assign {tdata, tlast, tvalid, tkeep} = s_axis_bus_i;

  state_e                      state_reg, state_next;
  logic                        tready_reg, tready_next;
  logic [pos_cnt_width_c-1:0]  t_cnt_reg;
  logic [pos_cnt_width_c-1:0]  p_cnt_reg;
  logic [7:0]                  exp_byte_reg;
  logic                        err_reg;
  logic [err_cnt_width_c-1:0]  err_cnt_reg;
  logic [beat_cnt_width_c-1:0] beat_cnt_reg;

  logic transfer;
  logic last_beat;
  logic beat_fail;
  logic bp_ok;

`ifdef CL_AXIS_TEST_SLAVE_BACKPRESSURE_EN
  cl_axis_lfsr #(
    .width_p(lfsr_width_c),
    .seed_p (lfsr_seed_c),
    .taps_p (lfsr_taps_c)
  ) lfsr_inst (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .out_o    (bp_ok)
  );
`else
  assign bp_ok = 1'b1;
`endif

  assign transfer  = tvalid && tready_reg;
  // Packet position comes from the beat counter, not from tlast, so a
  // bad tlast cannot shift the boundaries of later packets.
  assign last_beat = (t_cnt_reg == last_t_lp);
  assign beat_fail = (tdata != {keep_width_lp{exp_byte_reg}})
                  || (tlast != last_beat)
                  || (tkeep != {keep_width_lp{1'b1}});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (en_i) state_next = RECV;
      RECV: if (transfer && tlast && (p_cnt_reg == last_p_lp)) state_next = DONE;
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
    // Derived from the next state so tready drops in the same edge that
    // enters DONE; no beat can slip in after the final one.
    tready_next = (state_next == RECV) && en_i && bp_ok;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg    <= IDLE;
      tready_reg   <= 1'b0;
      t_cnt_reg    <= '0;
      p_cnt_reg    <= '0;
      exp_byte_reg <= 8'h00;
      err_reg      <= 1'b0;
      err_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      tready_reg <= tready_next;
      if (transfer) begin
        // Expected pattern advances even on failed beats, so a lost or
        // repeated beat keeps failing every later beat.
        exp_byte_reg <= exp_byte_reg + 8'd1;
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
        if (last_beat) begin
          t_cnt_reg <= '0;
          p_cnt_reg <= p_cnt_reg + 1'b1;
        end else begin
          t_cnt_reg <= t_cnt_reg + 1'b1;
        end
        if (beat_fail) begin
          err_reg <= 1'b1;
          if (err_cnt_reg != {err_cnt_width_c{1'b1}}) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  assign s_axis_bus_o = {{(axis_bus_width_lp-1){1'b0}}, tready_reg};
  assign done_o       = (state_reg == DONE);
  assign err_o        = err_reg;
  assign err_cnt_o    = err_cnt_reg;
  assign beat_cnt_o   = beat_cnt_reg;

endmodule

// File: tb/tb_cl_axis_test_slave.sv
// tb_cl_axis_test_slave
//   Directed bench: an incrementing-pattern master model drives 3
//   packets of 4 beats (64-bit data) with optional per-beat faults,
//   pauses or a mid-stream asynchronous reset.
module tb_cl_axis_test_slave;

  localparam int dw_lp  = 64;
  localparam int bw_lp  = dw_lp + dw_lp / 8 + 2;
  localparam int n_beats_lp = 12;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [bw_lp-1:0]  bus_i;
  logic [bw_lp-1:0]  bus_o;
  logic              done;
  logic              err;
  logic [15:0]       err_cnt;
  logic [31:0]       beat_cnt;

  logic [dw_lp-1:0]  tb_data;
  logic              tb_last;
  logic              tb_valid;
  logic [7:0]        tb_keep;

  int checks   = 0;
  int failures = 0;
  int stall_cycles;
  int fault_kind [n_beats_lp];

  assign bus_i = {tb_data, tb_last, tb_valid, tb_keep};

  always #5 clk = ~clk;

  cl_axis_test_slave #(
    .data_width_p (dw_lp),
    .packet_size_p(4),
    .pkts_num_p   (3)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .en_i        (en),
    .s_axis_bus_i(bus_i),
    .s_axis_bus_o(bus_o),
    .done_o      (done),
    .err_o       (err),
    .err_cnt_o   (err_cnt),
    .beat_cnt_o  (beat_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Beat b of the clean stream, then the planted fault for that beat.
  // Fault kinds: 1 flip bit 0 of byte 5, 2 invert tlast, 3 clear tkeep lane 0.
  task automatic drive_beat(input int b);
    logic [7:0] v;
    v        = b[7:0];
    tb_data  = {8{v}};
    tb_last  = ((b % 4) == 3);
    tb_keep  = 8'hFF;
    tb_valid = 1'b1;
    if (b < n_beats_lp) begin
      case (fault_kind[b])
        1: tb_data[40] = ~tb_data[40];
        2: tb_last     = ~tb_last;
        3: tb_keep[0]  = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic clear_faults();
    foreach (fault_kind[i]) fault_kind[i] = 0;
  endtask

  task automatic do_reset();
    tb_valid = 1'b0;
    tb_data  = '0;
    tb_last  = 1'b0;
    tb_keep  = '0;
    en       = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
  endtask

  // One cycle of the master: present beat idx at negedge, advance on
  // a transfer at the following posedge.
  task automatic step(inout int idx, inout bit early_done);
    logic rdy;
    @(negedge clk);
    drive_beat(idx);
    rdy = bus_o[0];
    if (done) early_done = 1'b1;
    if (!rdy && en) stall_cycles++;
    @(posedge clk);
    if (rdy) idx++;
  endtask

  task automatic run_stream(input string name, input int pause_at, input int abort_at,
                            input int exp_errs);
    int idx = 0;
    int cyc = 0;
    bit paused = 1'b0;
    bit early_done = 1'b0;
    stall_cycles = 0;
    en = 1'b1;
    while (idx < n_beats_lp && cyc < 400) begin
      if (idx == abort_at) begin
        #3 reset_n = 1'b0;
        #1;
        check_eq({name, "_rst_tready"}, 32'(bus_o[0]), 32'd0);
        check_eq({name, "_rst_done"}, 32'(done), 32'd0);
        check_eq({name, "_rst_err"}, 32'(err), 32'd0);
        check_eq({name, "_rst_errcnt"}, 32'(err_cnt), 32'd0);
        check_eq({name, "_rst_beatcnt"}, beat_cnt, 32'd0);
        $display("run %s: reset asserted after %0d beats", name, idx);
        return;
      end
      if (idx == pause_at && !paused) begin
        en = 1'b0;
        repeat (5) step(idx, early_done);
        @(negedge clk);
        check_eq({name, "_pause_tready"}, 32'(bus_o[0]), 32'd0);
        check_eq({name, "_pause_beatcnt"}, beat_cnt, 32'(idx));
        en = 1'b1;
        paused = 1'b1;
      end
      step(idx, early_done);
      cyc++;
    end
    check_eq({name, "_beats_taken"}, 32'(idx), 32'(n_beats_lp));
    @(negedge clk);
    check_eq({name, "_early_done"}, 32'(early_done), 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd1);
    check_eq({name, "_err"}, 32'(err), 32'(exp_errs != 0));
    check_eq({name, "_errcnt"}, 32'(err_cnt), 32'(exp_errs));
    check_eq({name, "_beatcnt"}, beat_cnt, 32'(n_beats_lp));
    // Master keeps offering a beat; a finished slave must ignore it.
    repeat (3) @(negedge clk);
    check_eq({name, "_tready_after"}, 32'(bus_o[0]), 32'd0);
    check_eq({name, "_beatcnt_after"}, beat_cnt, 32'(n_beats_lp));
    $display("run %s: %0d beats, err_cnt=%0d, stalls=%0d", name, idx, err_cnt, stall_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_faults();
    tb_valid = 1'b0;
    tb_data  = '0;
    tb_last  = 1'b0;
    tb_keep  = '0;
    en       = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_tready", 32'(bus_o[0]), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    check_eq("reset_errcnt", 32'(err_cnt), 32'd0);
    check_eq("reset_beatcnt", beat_cnt, 32'd0);
    reset_n = 1'b1;
    // Enable low: slave must stay in IDLE with tready low.
    repeat (3) @(negedge clk);
    check_eq("idle_tready", 32'(bus_o[0]), 32'd0);

    run_stream("clean", -1, -1, 0);
`ifdef CL_AXIS_TEST_SLAVE_BACKPRESSURE_EN
    check_eq("bp_stalls", 32'(stall_cycles > 1), 32'd1);
`endif

    do_reset();
    clear_faults();
    fault_kind[2] = 1;
    run_stream("corrupt_data", -1, -1, 1);

    do_reset();
    clear_faults();
    fault_kind[3] = 2;
    run_stream("missing_tlast", -1, -1, 1);

    do_reset();
    clear_faults();
    fault_kind[1] = 2;
    fault_kind[6] = 3;
    run_stream("early_tlast_tkeep", -1, -1, 2);

    do_reset();
    clear_faults();
    run_stream("pause", 5, -1, 0);

    do_reset();
    clear_faults();
    fault_kind[2] = 1;
    run_stream("abort", -1, 6, 0);
    do_reset();
    clear_faults();
    run_stream("after_abort", -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
